// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared square/coord types, piece constants and FSM states for the move controller
package chess_pkg;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef struct packed {
    logic [2:0] ptype;
    logic       colour;
    logic       occupied;
  } square_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } coord_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_RD   = 4'd1,
    S_EVAL = 4'd2,
    HELD   = 4'd3,
    D_RD   = 4'd4,
    D_EVAL = 4'd5,
    CHECK  = 4'd6,
    WR_DST = 4'd7,
    WR_SRC = 4'd8
  } state_t;

  function automatic logic is_own(square_t sq, logic side);
    return sq.occupied && (sq.colour == side);
  endfunction

  // A pawn reaching the far rank for its colour becomes a queen of the same colour.
  function automatic square_t promote_piece(square_t p, logic [2:0] dst_row);
    square_t    q;
    logic [2:0] last_row;
    q        = p;
    last_row = (p.colour == BLACK) ? 3'd7 : 3'd0;
    if (p.ptype == PAWN && dst_row == last_row) q.ptype = QUEEN;
    return q;
  endfunction

endpackage

// File: rtl/chess_move_ctrl_if.sv
// rtl/chess_move_ctrl_if.sv - board read/write port and legality-checker handshake bundle
interface chess_move_ctrl_if;

  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [4:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [4:0] wr_data;
  logic       chk_req;
  logic [4:0] chk_piece;
  logic [5:0] chk_src;
  logic [5:0] chk_dst;
  logic       chk_ack;
  logic       chk_legal;

  modport master (
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    output chk_req, chk_piece, chk_src, chk_dst,
    input  rd_data, chk_ack, chk_legal
  );

  modport slave (
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    input  chk_req, chk_piece, chk_src, chk_dst,
    output rd_data, chk_ack, chk_legal
  );

endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for an already-synchronised key level
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic prev;
  logic armed;

  // armed only sets once the key is seen low, so a key held through reset never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= key;
      if (!key) armed <= 1'b1;
    end
  end

  assign rise = key & ~prev & armed;

endmodule

// File: rtl/chess_move_ctrl.sv
// rtl/chess_move_ctrl.sv - select/place move sequencer; CHESS_AUTO_PROMOTE_EN enables pawn auto-promotion
module chess_move_ctrl
  import chess_pkg::*;
#(
  parameter int CHK_TIMEOUT = 255,
  parameter int CTR_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               select,
  input  logic               place,
  input  logic [2:0]         rowNum,
  input  logic [2:0]         columnNum,
  chess_move_ctrl_if.master  bus,
  output logic               turn,
  output logic               held,
  output logic               busy,
  output logic               move_done,
  output logic               err
);

  localparam logic [CTR_W-1:0] LAST_WAIT = CTR_W'(CHK_TIMEOUT - 1);

  state_t           state;
  square_t          piece_r;
  coord_t           src_r;
  coord_t           dst_r;
  logic [CTR_W-1:0] cnt;

  logic    sel_rise;
  logic    plc_rise;
  logic    sel_ev;
  logic    plc_ev;
  coord_t  cursor;
  square_t rd_sq;
  square_t dst_piece;

  btn_edge u_sel_edge (
    .clk   (clk),
    .reset (reset),
    .key   (select),
    .rise  (sel_rise)
  );

  btn_edge u_plc_edge (
    .clk   (clk),
    .reset (reset),
    .key   (place),
    .rise  (plc_rise)
  );

  assign sel_ev = sel_rise;
  assign plc_ev = plc_rise & ~sel_rise;
  assign cursor = {rowNum, columnNum};
  assign rd_sq  = square_t'(bus.rd_data);

`ifdef CHESS_AUTO_PROMOTE_EN
  assign dst_piece = promote_piece(piece_r, dst_r.row);
`else
  assign dst_piece = piece_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      turn          <= WHITE;
      held          <= 1'b0;
      busy          <= 1'b0;
      move_done     <= 1'b0;
      err           <= 1'b0;
      bus.rd_row    <= '0;
      bus.rd_col    <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_row    <= '0;
      bus.wr_col    <= '0;
      bus.wr_data   <= '0;
      bus.chk_req   <= 1'b0;
      bus.chk_piece <= '0;
      bus.chk_src   <= '0;
      bus.chk_dst   <= '0;
      piece_r       <= '0;
      src_r         <= '0;
      dst_r         <= '0;
      cnt           <= '0;
    end else begin
      move_done <= 1'b0;
      err       <= 1'b0;
      bus.wr_en <= 1'b0;

      case (state)
        IDLE: begin
          if (sel_ev) begin
            bus.rd_row <= cursor.row;
            bus.rd_col <= cursor.col;
            busy       <= 1'b1;
            state      <= S_RD;
          end else if (plc_ev) begin
            err <= 1'b1;
          end
        end

        S_RD: state <= S_EVAL;

        S_EVAL: begin
          busy <= 1'b0;
          if (is_own(rd_sq, turn)) begin
            piece_r <= rd_sq;
            src_r   <= {bus.rd_row, bus.rd_col};
            held    <= 1'b1;
            state   <= HELD;
          end else begin
            err   <= 1'b1;
            held  <= 1'b0;
            state <= IDLE;
          end
        end

        HELD: begin
          if (sel_ev) begin
            bus.rd_row <= cursor.row;
            bus.rd_col <= cursor.col;
            busy       <= 1'b1;
            state      <= S_RD;
          end else if (plc_ev) begin
            if (cursor == src_r) begin
              held  <= 1'b0;
              state <= IDLE;
            end else begin
              dst_r      <= cursor;
              bus.rd_row <= cursor.row;
              bus.rd_col <= cursor.col;
              busy       <= 1'b1;
              state      <= D_RD;
            end
          end
        end

        D_RD: state <= D_EVAL;

        // Landing on one of our own pieces simply moves the selection there.
        D_EVAL: begin
          if (is_own(rd_sq, turn)) begin
            piece_r <= rd_sq;
            src_r   <= dst_r;
            busy    <= 1'b0;
            state   <= HELD;
          end else begin
            bus.chk_req   <= 1'b1;
            bus.chk_piece <= piece_r;
            bus.chk_src   <= src_r;
            bus.chk_dst   <= dst_r;
            cnt           <= '0;
            state         <= CHECK;
          end
        end

        CHECK: begin
          if (bus.chk_ack) begin
            bus.chk_req <= 1'b0;
            if (bus.chk_legal) begin
              bus.wr_en   <= 1'b1;
              bus.wr_row  <= dst_r.row;
              bus.wr_col  <= dst_r.col;
              bus.wr_data <= dst_piece;
              state       <= WR_DST;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= HELD;
            end
          end else if (cnt == LAST_WAIT) begin
            bus.chk_req <= 1'b0;
            err         <= 1'b1;
            busy        <= 1'b0;
            state       <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Second commit write plus the move-complete side effects, all visible in WR_SRC.
        WR_DST: begin
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= src_r.row;
          bus.wr_col  <= src_r.col;
          bus.wr_data <= '0;
          move_done   <= 1'b1;
          turn        <= ~turn;
          held        <= 1'b0;
          state       <= WR_SRC;
        end

        WR_SRC: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          held  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chess_move_ctrl.sv
// tb/tb_chess_move_ctrl.sv - randomized move sequences checked against a board-level reference model
module tb_chess_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       select = 1'b0;
  logic       place = 1'b0;
  logic [2:0] rowNum = 3'd0;
  logic [2:0] columnNum = 3'd0;
  logic       turn, held, busy, move_done, err;

  chess_move_ctrl_if bus();

  chess_move_ctrl #(.CHK_TIMEOUT(255), .CTR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .select    (select),
    .place     (place),
    .rowNum    (rowNum),
    .columnNum (columnNum),
    .bus       (bus),
    .turn      (turn),
    .held      (held),
    .busy      (busy),
    .move_done (move_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Board store: registered read, written by the DUT, loadable by the bench.
  logic [4:0] board [64];
  logic       tb_load = 1'b0;
  logic       tb_poke = 1'b0;
  int         poke_idx = 0;
  logic [4:0] poke_val = 5'd0;

  function automatic logic [4:0] start_sq(int idx);
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int r = idx / 8;
    int c = idx % 8;
    if (r == 0) return 5'((back[c] << 2) | 3);
    if (r == 1) return 5'((1 << 2) | 3);
    if (r == 6) return 5'((1 << 2) | 1);
    if (r == 7) return 5'((back[c] << 2) | 1);
    return 5'd0;
  endfunction

  always @(posedge clk) begin
    bus.rd_data <= board[{bus.rd_row, bus.rd_col}];
    if (tb_load) begin
      for (int i = 0; i < 64; i++) board[i] <= start_sq(i);
    end else if (tb_poke) begin
      board[poke_idx] <= poke_val;
    end
    if (bus.wr_en) board[{bus.wr_row, bus.wr_col}] <= bus.wr_data;
  end

  // Monitor
  typedef struct {
    int cyc;
    int idx;
    int data;
  } wr_t;
  wr_t wr_log[$];
  int  cyc = 0;
  int  err_cnt = 0;
  int  done_cnt = 0;
  int  req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en) wr_log.push_back('{cyc, int'({bus.wr_row, bus.wr_col}), int'(bus.wr_data)});
    if (err) err_cnt <= err_cnt + 1;
    if (move_done) done_cnt <= done_cnt + 1;
    if (bus.chk_req) req_cyc <= req_cyc + 1;
  end

  // Legality checker responder
  int resp_mode = 0;
  int resp_delay = 0;
  int cap_piece = 0, cap_src = 0, cap_dst = 0;
  int unstable = 0;

  initial begin
    int  wait_left;
    bit  in_req;
    wait_left = 0;
    in_req = 0;
    bus.chk_ack = 1'b0;
    bus.chk_legal = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.chk_ack) begin
        bus.chk_ack = 1'b0;
        bus.chk_legal = 1'b0;
        in_req = 0;
      end else if (bus.chk_req && !reset) begin
        if (!in_req) begin
          in_req = 1;
          cap_piece = bus.chk_piece;
          cap_src = bus.chk_src;
          cap_dst = bus.chk_dst;
          wait_left = resp_delay;
        end else if (cap_piece != bus.chk_piece || cap_src != bus.chk_src || cap_dst != bus.chk_dst) begin
          unstable++;
        end
        if (resp_mode != 2) begin
          if (wait_left == 0) begin
            bus.chk_ack = 1'b1;
            bus.chk_legal = (resp_mode == 0);
          end else begin
            wait_left--;
          end
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Reference model: board contents, side to move, selection.
  logic [4:0] m_board [64];
  int m_turn = 0;
  int m_held = 0;
  int m_src = 0;
  int m_piece = 0;

  function automatic int promo(int p, int dst);
`ifdef CHESS_AUTO_PROMOTE_EN
    int far_row = ((p >> 1) & 1) ? 7 : 0;
    if ((p >> 2) == 1 && (dst / 8) == far_row) return (5 << 2) | (p & 3);
`endif
    return p + (dst * 0);
  endfunction

  function automatic int board_diff();
    int n = 0;
    for (int i = 0; i < 64; i++) if (board[i] !== m_board[i]) n++;
    return n;
  endfunction

  function automatic bit is_own(int sq);
    return (sq & 1) == 1 && ((sq >> 1) & 1) == m_turn;
  endfunction

  task automatic load_start();
    @(negedge clk); tb_load = 1'b1;
    @(negedge clk); tb_load = 1'b0;
    for (int i = 0; i < 64; i++) m_board[i] = start_sq(i);
  endtask

  task automatic poke(int idx, int val);
    @(negedge clk); poke_idx = idx; poke_val = 5'(val); tb_poke = 1'b1;
    @(negedge clk); tb_poke = 1'b0;
    m_board[idx] = 5'(val);
  endtask

  task automatic press(bit s, bit p, int r, int c);
    @(negedge clk);
    rowNum = 3'(r); columnNum = 3'(c);
    select = s; place = p;
    @(negedge clk);
    select = 1'b0; place = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    check("settle_busy", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_select(int r, int c, bit with_place);
    int idx, exp_err, e0, w0, q0;
    idx = r * 8 + c;
    if (is_own(m_board[idx])) begin
      exp_err = 0; m_held = 1; m_src = idx; m_piece = m_board[idx];
    end else begin
      exp_err = 1; m_held = 0;
    end
    e0 = err_cnt; w0 = wr_log.size(); q0 = req_cyc;
    press(1'b1, with_place, r, c);
    settle();
    check("sel_err", err_cnt - e0, exp_err);
    check("sel_held", held, m_held);
    check("sel_turn", turn, m_turn);
    check("sel_no_wr", wr_log.size() - w0, 0);
    check("sel_no_chk", req_cyc - q0, 0);
  endtask

  task automatic do_place(int r, int c, int mode, bit poke_sel, bit rst_wr);
    int idx, dsq, exp_err, exp_chk, exp_nwr, exp_done, p_piece, p_src, wpiece;
    int e0, d0, w0, q0, n;
    idx = r * 8 + c;
    exp_err = 0; exp_chk = 0; exp_nwr = 0; exp_done = 0; wpiece = 0;
    p_piece = m_piece; p_src = m_src;
    if (m_held == 0) begin
      exp_err = 1;
    end else if (idx == m_src) begin
      m_held = 0;
    end else begin
      dsq = m_board[idx];
      if (is_own(dsq)) begin
        m_src = idx; m_piece = dsq;
      end else begin
        exp_chk = 1;
        if (mode == 0) begin
          wpiece = promo(m_piece, idx);
          m_board[idx] = 5'(wpiece);
          m_held = 0;
          if (rst_wr) begin
            exp_nwr = 1; m_turn = 0;
          end else begin
            m_board[m_src] = 5'd0; exp_nwr = 2; exp_done = 1; m_turn ^= 1;
          end
        end else begin
          exp_err = 1;
        end
      end
    end
    resp_mode = mode;
    resp_delay = poke_sel ? 6 : int'($urandom_range(0, 3));
    e0 = err_cnt; d0 = done_cnt; w0 = wr_log.size(); q0 = req_cyc;
    press(1'b0, 1'b1, r, c);
    if (poke_sel) begin
      n = 0;
      while (!bus.chk_req && n < 20) begin @(negedge clk); n++; end
      check("poke_req_seen", bus.chk_req, 1);
      press(1'b1, 1'b0, r, c);
    end
    if (rst_wr) begin
      n = 0;
      while (!bus.wr_en && n < 50) begin @(negedge clk); n++; end
      check("wr_dst_seen", bus.wr_en, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_outs", {turn, held, busy, bus.wr_en, bus.chk_req, move_done, err}, 0);
      reset = 1'b0;
    end
    settle();
    check("plc_err", err_cnt - e0, exp_err);
    check("plc_held", held, m_held);
    check("plc_turn", turn, m_turn);
    check("plc_done", done_cnt - d0, exp_done);
    check("plc_nwr", wr_log.size() - w0, exp_nwr);
    check("plc_chk_seen", (req_cyc - q0) != 0, exp_chk);
    if (exp_nwr >= 1) begin
      check("wr_dst_addr", wr_log[w0].idx, idx);
      check("wr_dst_data", wr_log[w0].data, wpiece);
    end
    if (exp_nwr == 2) begin
      check("wr_src_addr", wr_log[w0 + 1].idx, p_src);
      check("wr_src_data", wr_log[w0 + 1].data, 0);
      check("wr_consecutive", wr_log[w0 + 1].cyc - wr_log[w0].cyc, 1);
    end
    if (exp_chk == 1) begin
      check("chk_piece", cap_piece, p_piece);
      check("chk_src", cap_src, p_src);
      check("chk_dst", cap_dst, idx);
      check("chk_stable", unstable, 0);
    end
    if (exp_chk == 1 && mode == 2) check("timeout_len", req_cyc - q0, 255);
    check("board", board_diff(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, idx, j, mode, pick;
    bus.rd_data = 5'd0;
    reset = 1'b1;
    load_start();
    repeat (2) @(negedge clk);
    check("reset_outs", {turn, held, busy, bus.wr_en, bus.chk_req, move_done, err}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_outs", {turn, held, busy, bus.wr_en, bus.chk_req, move_done, err}, 0);

    // Opening moves, wrong-colour select, reselect via own piece, illegal then legal.
    do_select(6, 4, 1'b0);
    do_place(4, 4, 0, 1'b0, 1'b0);
    do_select(1, 4, 1'b0);
    do_place(3, 4, 0, 1'b0, 1'b0);
    do_select(1, 0, 1'b0);
    do_select(7, 1, 1'b0);
    do_place(7, 2, 0, 1'b0, 1'b0);
    do_place(7, 1, 0, 1'b0, 1'b0);
    do_place(5, 2, 1, 1'b0, 1'b0);
    do_place(5, 2, 0, 1'b0, 1'b0);

    // Checker timeout, then deselect, then place with nothing held.
    do_select(0, 1, 1'b0);
    do_place(2, 2, 2, 1'b0, 1'b0);
    do_place(0, 1, 0, 1'b0, 1'b0);
    do_place(3, 3, 0, 1'b0, 1'b0);

    // Simultaneous select+place, and a select pressed during CHECK.
    do_select(0, 6, 1'b1);
    do_place(2, 5, 0, 1'b1, 1'b0);

    // Reset while the destination write is on the bus.
    do_select(6, 0, 1'b0);
    do_place(5, 0, 0, 1'b0, 1'b1);
    load_start();

    // Pawn reaching the last rank.
    poke(1 * 8 + 3, 5'b00101);
    do_select(1, 3, 1'b0);
    do_place(0, 3, 0, 1'b0, 1'b0);
    load_start();

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 99);
      if (op < 30 || (m_held == 0 && op < 90)) begin
        idx = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) begin
          for (int t = 0; t < 64; t++) begin
            j = (idx + t) % 64;
            if (is_own(m_board[j])) begin idx = j; break; end
          end
        end
        do_select(idx / 8, idx % 8, 1'b0);
      end else begin
        idx = ($urandom_range(0, 9) == 0) ? m_src : int'($urandom_range(0, 63));
        pick = $urandom_range(0, 99);
        mode = (pick < 65) ? 0 : ((pick < 97) ? 1 : 2);
        do_place(idx / 8, idx % 8, mode, 1'b0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_move_ctrl.md
Name: chess_move_ctrl

Overview:
- Sequences every move on the 8x8 board store (5-bit square codes: bit0 occupied, bit1 colour with 0=white and 1=black, bits4:2 piece type).
- Converts select/place button presses and the cursor position into board reads, a legality-check handshake, and a two-write move commit. Turns alternate between white and black.
- Sits between the positionCounter cursor logic, the board register file (also read by the VGA path), and the move-legality checker.

Parameters:
- CHK_TIMEOUT, 255: cycles to wait for chk_ack before the move is treated as illegal.
- CTR_W, 8: width of the timeout counter; must satisfy CHK_TIMEOUT < 2**CTR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- select  in  1  raw select key, level, already synchronised; rising edge detected internally
- place  in  1  raw place key, level, already synchronised; rising edge detected internally
- rowNum  in  3  cursor row
- columnNum  in  3  cursor column
- rd_row  out  3  board read address, row
- rd_col  out  3  board read address, column
- rd_data  in  5  board read data, valid one cycle after address
- wr_en  out  1  board write strobe
- wr_row  out  3  board write address, row
- wr_col  out  3  board write address, column
- wr_data  out  5  board write data
- chk_req  out  1  legality request, held until chk_ack
- chk_piece  out  5  piece under test
- chk_src  out  6  {row,col} of the source square
- chk_dst  out  6  {row,col} of the destination square
- chk_ack  in  1  checker response valid (single-cycle pulse)
- chk_legal  in  1  legality verdict, sampled with chk_ack
- turn  out  1  side to move: 0=white, 1=black
- held  out  1  a piece is currently selected
- busy  out  1  FSM is not in IDLE or HELD
- move_done  out  1  one-cycle pulse when a move commits
- err  out  1  one-cycle pulse on a rejected select or place

Behaviour:
- Reset values (every output and register): state IDLE; turn=0; held=0; busy=0; wr_en=0; chk_req=0; move_done=0; err=0; source and piece registers=0.
- Edge-detect registers reset to 0, so a key held through reset does not produce an event.
- Event acceptance:
  - Events are accepted only in IDLE or HELD; events in any other state are dropped.
  - If select and place edges occur in the same cycle, select wins and place is dropped.
  - The cursor is latched on the event cycle.
- FSM states: IDLE, S_RD, S_EVAL, HELD, D_RD, D_EVAL, CHECK, WR_DST, WR_SRC.
- IDLE:
  - select edge -> S_RD, driving rd = cursor.
  - place edge -> err pulse, stay in IDLE.
- S_RD -> S_EVAL: one-cycle read latency.
- S_EVAL:
  - If rd_data[0]=1 and rd_data[1]=turn: latch piece and source, set held=1, go to HELD.
  - Otherwise: err pulse, go to IDLE.
- HELD:
  - select edge -> S_RD (reselect; held stays 1 until S_EVAL decides).
  - place edge where destination equals source -> deselect: held=0, go to IDLE, no err.
  - any other place edge -> D_RD.
- D_RD -> D_EVAL: read the destination square.
- D_EVAL:
  - Destination occupied by the side to move: treated as a reselect of that piece, go to HELD, no err.
  - Destination occupied by the other side, or empty: go to CHECK.
- CHECK:
  - chk_req=1, with chk_* stable for the whole request.
  - chk_ack with chk_legal=1 -> WR_DST.
  - chk_ack with chk_legal=0 -> err pulse, go to HELD (piece stays selected).
  - Timeout counter is cleared on entry. If it reaches CHK_TIMEOUT with no ack: drop chk_req, err pulse, go to HELD.
  - chk_ack outside CHECK is ignored.
- WR_DST: wr_en=1, wr_data=piece, address=destination.
- WR_SRC: wr_en=1, wr_data=5'b00000, address=source. Same cycle: move_done=1, turn toggles, held=0, next state IDLE.
- Latency: the two commit writes land in consecutive cycles.
  - Select press to held=1: 3 cycles (S_RD, S_EVAL, HELD).
  - Place press to first write: at least 4 cycles.
- At most one wr_en per cycle, and never outside WR_DST or WR_SRC.
- Reset mid-operation (any state, including WR_DST): return to reset values next cycle. No write after reset is sampled. A half-committed move (destination written, source not yet cleared) is accepted as board corruption; the board store is reloaded by its own reset.

Optional Feature:
- Macro: CHESS_AUTO_PROMOTE_EN.
- Defined: in WR_DST, a pawn (type 001) landing on row 0 (white) or row 7 (black) is written as a queen, i.e. bits4:2=101 with the colour bit kept (white 10101, black 10111).
- Undefined: the piece is written unchanged.

Decomposition:
- Package chess_pkg holds:
  - the square typedef (5-bit packed struct: type, colour, occupied);
  - piece-type constants: EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING;
  - colour constants WHITE and BLACK;
  - the FSM state enum;
  - a coord typedef of {row,col} 6 bits.
- One sub-module, btn_edge: a rise detector, instantiated twice (select, place).

Test Plan:
- Start board; select at [6][4] (rd_data=00101), then place at [4][4], checker ack legal -> writes [4][4]=00101 then [6][4]=00000 in consecutive cycles; move_done pulses; turn 0->1.
- turn=0; select at [1][0] (00111, black pawn) -> err pulse; held stays 0; no chk_req, no wr_en.
- Held white knight at [7][1]; checker acks illegal -> err pulse; held=1; no writes; next legal place commits normally.
- Checker never acks, CHK_TIMEOUT=255 -> chk_req drops at the 255th cycle with an err pulse; held=1.
- Select and place rising in the same cycle, and select pressed during CHECK -> select is handled, place is dropped; the press during CHECK is ignored.
- Reset asserted in WR_DST -> no WR_SRC write; turn=0, held=0. With CHESS_AUTO_PROMOTE_EN, a white pawn moving [1][3]->[0][3] writes 10101.
